// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - states, opcode classes and ALU map for the control sequencer
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        S_RESET, S_IDLE,
        S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7,
        S_HALTED
    } state_t;

    typedef enum logic [3:0] {
        CLS_LD, CLS_LDI, CLS_ST, CLS_ALU_R, CLS_ALU_I,
        CLS_BR, CLS_NOP, CLS_HALT, CLS_ILLEGAL
    } opc_class_t;

    localparam logic [4:0] OPC_LD       = 5'b00000;
    localparam logic [4:0] OPC_LDI      = 5'b00001;
    localparam logic [4:0] OPC_ST       = 5'b00010;
    localparam logic [4:0] OPC_ALU_R_LO = 5'b00011;
    localparam logic [4:0] OPC_ALU_R_HI = 5'b01011;
    localparam logic [4:0] OPC_ADDI     = 5'b01100;
    localparam logic [4:0] OPC_ANDI     = 5'b01101;
    localparam logic [4:0] OPC_ORI      = 5'b01110;
    localparam logic [4:0] OPC_BR       = 5'b10010;
    localparam logic [4:0] OPC_NOP      = 5'b11010;
    localparam logic [4:0] OPC_HALT     = 5'b11011;

    localparam logic [4:0] ALU_ADD = 5'b00011;
    localparam logic [4:0] ALU_SUB = 5'b00100;
    localparam logic [4:0] ALU_AND = 5'b00101;
    localparam logic [4:0] ALU_OR  = 5'b00110;

    function automatic opc_class_t classify(input logic [4:0] opc);
        opc_class_t c;
        if (opc == OPC_LD)                                    c = CLS_LD;
        else if (opc == OPC_LDI)                              c = CLS_LDI;
        else if (opc == OPC_ST)                               c = CLS_ST;
        else if (opc >= OPC_ALU_R_LO && opc <= OPC_ALU_R_HI)  c = CLS_ALU_R;
        else if (opc >= OPC_ADDI && opc <= OPC_ORI)           c = CLS_ALU_I;
        else if (opc == OPC_BR)                               c = CLS_BR;
        else if (opc == OPC_NOP)                              c = CLS_NOP;
        else if (opc == OPC_HALT)                             c = CLS_HALT;
        else                                                  c = CLS_ILLEGAL;
        return c;
    endfunction

    // Register-form ALU opcodes share their encoding with the ALU function;
    // immediates fold onto their register counterpart, everything else adds.
    function automatic logic [4:0] alu_map(input logic [4:0] opc);
        logic [4:0] op;
        if (opc >= OPC_ALU_R_LO && opc <= OPC_ALU_R_HI) op = opc;
        else if (opc == OPC_ANDI)                       op = ALU_AND;
        else if (opc == OPC_ORI)                        op = ALU_OR;
        else                                            op = ALU_ADD;
        return op;
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// rtl/control_sequencer_if.sv - control bus between sequencer and datapath
interface control_sequencer_if #(
    parameter int OPC_W    = 5,
    parameter int ALU_OP_W = 5
);
    logic [OPC_W-1:0]    ir_opcode;
    logic                con_ff;
    logic                mem_ready;
    logic                pause;

    logic PCout, ZLowOut, ZHighOut, MDRout, Cout, BAout, Rout;
    logic PCin, MARin, MDRin, IRin, Yin, Zin, Rin, CONin;
    logic Gra, Grb, Grc, IncPC, MDRread, W_sig;
    logic [ALU_OP_W-1:0] operation;
    logic                Clear;
    logic                run;
    logic [3:0]          step;
    logic                illegal_op;
    logic                mem_timeout;

    modport master (
        input  ir_opcode, con_ff, mem_ready, pause,
        output PCout, ZLowOut, ZHighOut, MDRout, Cout, BAout, Rout,
        output PCin, MARin, MDRin, IRin, Yin, Zin, Rin, CONin,
        output Gra, Grb, Grc, IncPC, MDRread, W_sig,
        output operation, Clear, run, step, illegal_op, mem_timeout
    );

    modport slave (
        output ir_opcode, con_ff, mem_ready, pause,
        input  PCout, ZLowOut, ZHighOut, MDRout, Cout, BAout, Rout,
        input  PCin, MARin, MDRin, IRin, Yin, Zin, Rin, CONin,
        input  Gra, Grb, Grc, IncPC, MDRread, W_sig,
        input  operation, Clear, run, step, illegal_op, mem_timeout
    );
endinterface

// File: rtl/mem_wait_ctr.sv
// rtl/mem_wait_ctr.sv - memory stall counter with sticky timeout flag
module mem_wait_ctr #(
    parameter int WAIT_LIMIT    = 15,
    parameter bit ZERO_WAIT_MEM = 1'b0
) (
    input  logic clk,
    input  logic clr,
    input  logic mem_step_i,
    input  logic mem_ready_i,
    output logic advance_o,
    output logic first_o,
    output logic timeout_o
);
    localparam int CW = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);
    localparam logic [CW-1:0] LAST = CW'(WAIT_LIMIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          timeout_q, timeout_d;

    // A stall on the final allowed cycle forces the step forward and latches the timeout.
    always_comb begin
        advance_o = 1'b1;
        cnt_d     = '0;
        timeout_d = timeout_q;
        if (mem_step_i && !ZERO_WAIT_MEM && !mem_ready_i) begin
            if (cnt_q == LAST) begin
                timeout_d = 1'b1;
            end else begin
                advance_o = 1'b0;
                cnt_d     = cnt_q + 1'b1;
            end
        end
    end

    // Counter restarts on every new memory step; timeout only clears on clr.
    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign first_o   = (cnt_q == '0);
    assign timeout_o = timeout_q;
endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - hardwired fetch/execute control unit
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int OPC_W         = 5,
    parameter int ALU_OP_W      = 5,
    parameter bit ZERO_WAIT_MEM = 1'b0,
    parameter int WAIT_LIMIT    = 15
) (
    input  logic                clk,
    input  logic                clr,
    control_sequencer_if.master bus
);
    state_t          state_q, state_d;
    logic [OPC_W-1:0] opc_raw;
    logic [4:0]      opc;
    opc_class_t      cls;
    logic            mem_step, mem_adv, mem_first;
    state_t          boundary;

    assign opc_raw  = bus.ir_opcode;
    assign opc      = 5'(opc_raw);
    assign cls      = classify(opc);
    assign boundary = bus.pause ? S_IDLE : S_T0;
    assign mem_step = (state_q == S_T1)
                   || (state_q == S_T6 && cls == CLS_LD)
                   || (state_q == S_T7 && cls == CLS_ST);

    mem_wait_ctr #(
        .WAIT_LIMIT   (WAIT_LIMIT),
        .ZERO_WAIT_MEM(ZERO_WAIT_MEM)
    ) u_wait (
        .clk        (clk),
        .clr        (clr),
        .mem_step_i (mem_step),
        .mem_ready_i(bus.mem_ready),
        .advance_o  (mem_adv),
        .first_o    (mem_first),
        .timeout_o  (bus.mem_timeout)
    );

    // Step sequencing: each class ends at the instruction boundary, where pause is sampled.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RESET:  state_d = S_T0;
            S_IDLE:   state_d = bus.pause ? S_IDLE : S_T0;
            S_T0:     state_d = S_T1;
            S_T1:     state_d = mem_adv ? S_T2 : S_T1;
            S_T2: begin
                if (cls == CLS_HALT)                              state_d = S_HALTED;
                else if (cls == CLS_NOP || cls == CLS_ILLEGAL)    state_d = boundary;
                else                                              state_d = S_T3;
            end
            S_T3:     state_d = S_T4;
            S_T4:     state_d = S_T5;
            S_T5: begin
                if (cls == CLS_LD || cls == CLS_ST || cls == CLS_BR) state_d = S_T6;
                else                                                 state_d = boundary;
            end
            S_T6: begin
                if (cls == CLS_LD)      state_d = mem_adv ? S_T7 : S_T6;
                else if (cls == CLS_ST) state_d = S_T7;
                else                    state_d = boundary;
            end
            S_T7: begin
                if (cls == CLS_ST) state_d = mem_adv ? boundary : S_T7;
                else               state_d = boundary;
            end
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_RESET;
        endcase
    end

    // State register; clr aborts whatever step is in flight.
    always_ff @(posedge clk) begin
        if (clr) state_q <= S_RESET;
        else     state_q <= state_d;
    end

    // Strobe decode from the current step and opcode class.
    always_comb begin
        bus.PCout = 1'b0; bus.ZLowOut = 1'b0; bus.ZHighOut = 1'b0; bus.MDRout = 1'b0;
        bus.Cout  = 1'b0; bus.BAout   = 1'b0; bus.Rout     = 1'b0;
        bus.PCin  = 1'b0; bus.MARin   = 1'b0; bus.MDRin    = 1'b0; bus.IRin   = 1'b0;
        bus.Yin   = 1'b0; bus.Zin     = 1'b0; bus.Rin      = 1'b0; bus.CONin  = 1'b0;
        bus.Gra   = 1'b0; bus.Grb     = 1'b0; bus.Grc      = 1'b0; bus.IncPC  = 1'b0;
        bus.MDRread = 1'b0; bus.W_sig = 1'b0;
        bus.operation  = '0;
        bus.Clear      = 1'b0;
        bus.run        = 1'b1;
        bus.step       = 4'd0;
        bus.illegal_op = 1'b0;
        case (state_q)
            S_RESET:  bus.Clear = 1'b1;
            S_HALTED: bus.run   = 1'b0;
            S_T0: begin
                bus.step = 4'd0;
                bus.PCout = 1'b1; bus.MARin = 1'b1; bus.IncPC = 1'b1; bus.Zin = 1'b1;
            end
            S_T1: begin
                bus.step = 4'd1;
                bus.ZLowOut = 1'b1; bus.MDRread = 1'b1; bus.MDRin = 1'b1;
                bus.PCin = mem_first;
            end
            S_T2: begin
                bus.step = 4'd2;
                bus.MDRout = 1'b1; bus.IRin = 1'b1;
                bus.illegal_op = (cls == CLS_ILLEGAL);
            end
            S_T3: begin
                bus.step = 4'd3;
                case (cls)
                    CLS_ALU_R, CLS_ALU_I:     begin bus.Grb = 1'b1; bus.Rout  = 1'b1; bus.Yin = 1'b1; end
                    CLS_LDI, CLS_LD, CLS_ST:  begin bus.Grb = 1'b1; bus.BAout = 1'b1; bus.Yin = 1'b1; end
                    CLS_BR:                   begin bus.Gra = 1'b1; bus.Rout  = 1'b1; bus.CONin = 1'b1; end
                    default: ;
                endcase
            end
            S_T4: begin
                bus.step = 4'd4;
                case (cls)
                    CLS_ALU_R: begin
                        bus.Grc = 1'b1; bus.Rout = 1'b1; bus.Zin = 1'b1;
                        bus.operation = ALU_OP_W'(alu_map(opc));
                    end
                    CLS_ALU_I, CLS_LDI, CLS_LD, CLS_ST: begin
                        bus.Cout = 1'b1; bus.Zin = 1'b1;
                        bus.operation = ALU_OP_W'(alu_map(opc));
                    end
                    CLS_BR: begin bus.PCout = 1'b1; bus.Yin = 1'b1; end
                    default: ;
                endcase
            end
            S_T5: begin
                bus.step = 4'd5;
                case (cls)
                    CLS_ALU_R, CLS_ALU_I, CLS_LDI: begin bus.ZLowOut = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
                    CLS_LD, CLS_ST:                begin bus.ZLowOut = 1'b1; bus.MARin = 1'b1; end
                    CLS_BR: begin
                        bus.Cout = 1'b1; bus.Zin = 1'b1;
                        bus.operation = ALU_OP_W'(ALU_ADD);
                    end
                    default: ;
                endcase
            end
            S_T6: begin
                bus.step = 4'd6;
                case (cls)
                    CLS_LD: begin bus.MDRread = 1'b1; bus.MDRin = 1'b1; end
                    CLS_ST: begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.MDRin = 1'b1; end
                    CLS_BR: begin bus.ZLowOut = bus.con_ff; bus.PCin = bus.con_ff; end
                    default: ;
                endcase
            end
            S_T7: begin
                bus.step = 4'd7;
                case (cls)
                    CLS_LD:  begin bus.MDRout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
                    CLS_ST:  bus.W_sig = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - trace-model bench for control_sequencer
module tb_control_sequencer;
    localparam int WAIT_LIMIT = 15;

    localparam logic [20:0] PCOUT = 21'h000001, ZLO   = 21'h000002, ZHI   = 21'h000004;
    localparam logic [20:0] MDROUT= 21'h000008, COUT  = 21'h000010, BAOUT = 21'h000020;
    localparam logic [20:0] ROUT  = 21'h000040, PCIN  = 21'h000080, MARIN = 21'h000100;
    localparam logic [20:0] MDRIN = 21'h000200, IRIN  = 21'h000400, YIN   = 21'h000800;
    localparam logic [20:0] ZIN   = 21'h001000, RIN   = 21'h002000, CONIN = 21'h004000;
    localparam logic [20:0] GRA   = 21'h008000, GRB   = 21'h010000, GRC   = 21'h020000;
    localparam logic [20:0] INCPC = 21'h040000, MDRRD = 21'h080000, WSIG  = 21'h100000;

    typedef struct packed {
        logic [20:0] s;
        logic [4:0]  op;
        logic        clear;
        logic        run;
        logic [3:0]  step;
        logic        ill;
        logic        to;
    } word_t;

    typedef struct {
        word_t      w;
        logic       rdy;
        logic [4:0] opc;
        logic       con;
        logic       pau;
        logic       clr;
        int         id;
    } ent_t;

    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    control_sequencer_if #(.OPC_W(5), .ALU_OP_W(5)) bus ();

    control_sequencer #(
        .OPC_W(5), .ALU_OP_W(5), .ZERO_WAIT_MEM(1'b0), .WAIT_LIMIT(WAIT_LIMIT)
    ) dut (
        .clk(clk),
        .clr(clr),
        .bus(bus)
    );

    word_t obs;
    always_comb begin
        obs.s = {bus.W_sig, bus.MDRread, bus.IncPC, bus.Grc, bus.Grb, bus.Gra, bus.CONin,
                 bus.Rin, bus.Zin, bus.Yin, bus.IRin, bus.MDRin, bus.MARin, bus.PCin,
                 bus.Rout, bus.BAout, bus.Cout, bus.MDRout, bus.ZHighOut, bus.ZLowOut, bus.PCout};
        obs.op    = bus.operation;
        obs.clear = bus.Clear;
        obs.run   = bus.run;
        obs.step  = bus.step;
        obs.ill   = bus.illegal_op;
        obs.to    = bus.mem_timeout;
    end

    ent_t       q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         m_id = 0;
    logic [4:0] m_opc = 5'd3;
    logic       m_con = 1'b0;
    logic       m_pau = 1'b0;
    logic       m_to  = 1'b0;

    logic [4:0] def_ops [17] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8,
                                 5'd9, 5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd18, 5'd26};
    logic [4:0] bad_ops [14] = '{5'd15, 5'd16, 5'd17, 5'd19, 5'd20, 5'd21, 5'd22,
                                 5'd23, 5'd24, 5'd25, 5'd28, 5'd29, 5'd30, 5'd31};

    function automatic bit is_defined(input logic [4:0] opc);
        return (opc <= 5'd14) || (opc == 5'd18) || (opc == 5'd26) || (opc == 5'd27);
    endfunction

    function automatic logic [4:0] exp_op(input logic [4:0] opc);
        if (opc >= 5'd3 && opc <= 5'd11) return opc;
        if (opc == 5'd13) return 5'd5;
        if (opc == 5'd14) return 5'd6;
        return 5'd3;
    endfunction

    task automatic push(input logic [20:0] s, input logic [4:0] op, input logic [3:0] stp,
                        input logic rdy, input logic ill, input logic run, input logic clear);
        ent_t e;
        e.w.s = s; e.w.op = op; e.w.clear = clear; e.w.run = run;
        e.w.step = stp; e.w.ill = ill; e.w.to = m_to;
        e.rdy = rdy; e.opc = m_opc; e.con = m_con; e.pau = m_pau; e.clr = 1'b0; e.id = m_id;
        q.push_back(e);
    endtask

    task automatic push_t(input logic [20:0] s, input logic [4:0] op, input logic [3:0] stp);
        push(s, op, stp, 1'($urandom), 1'b0, 1'b1, 1'b0);
    endtask

    // A memory step stalls `stall` cycles then completes; WAIT_LIMIT or more means it times out.
    task automatic mem_t(input logic [20:0] s, input logic [3:0] stp, input int stall, input bit pcin_first);
        int n;
        n = (stall >= WAIT_LIMIT) ? WAIT_LIMIT : stall + 1;
        for (int i = 0; i < n; i++)
            push(s | ((pcin_first && i == 0) ? PCIN : 21'd0), 5'd0, stp,
                 (stall < WAIT_LIMIT && i == stall), 1'b0, 1'b1, 1'b0);
        if (stall >= WAIT_LIMIT) m_to = 1'b1;
    endtask

    task automatic push_reset(input logic clr_v);
        push(21'd0, 5'd0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1);
        q[q.size()-1].clr = clr_v;
    endtask

    task automatic do_clr();
        q[q.size()-1].clr = 1'b1;
        m_to = 1'b0;
        push_reset(1'b0);
    endtask

    task automatic add_instr(input logic [4:0] opc, input logic con, input int st1,
                             input int st2, input bit abort6);
        m_id++;
        m_opc = opc;
        m_con = con;
        push_t(PCOUT | MARIN | INCPC | ZIN, 5'd0, 4'd0);
        mem_t(ZLO | MDRRD | MDRIN, 4'd1, st1, 1'b1);
        push(MDROUT | IRIN, 5'd0, 4'd2, 1'($urandom), !is_defined(opc), 1'b1, 1'b0);
        if (opc == 5'd27) begin
            repeat (4) push(21'd0, 5'd0, 4'd0, 1'($urandom), 1'b0, 1'b0, 1'b0);
        end else if (opc >= 5'd3 && opc <= 5'd11) begin
            push_t(GRB | ROUT | YIN, 5'd0, 4'd3);
            push_t(GRC | ROUT | ZIN, exp_op(opc), 4'd4);
            push_t(ZLO | GRA | RIN, 5'd0, 4'd5);
        end else if (opc inside {5'd1, 5'd12, 5'd13, 5'd14}) begin
            push_t(GRB | YIN | ((opc == 5'd1) ? BAOUT : ROUT), 5'd0, 4'd3);
            push_t(COUT | ZIN, exp_op(opc), 4'd4);
            push_t(ZLO | GRA | RIN, 5'd0, 4'd5);
        end else if (opc == 5'd0 || opc == 5'd2) begin
            push_t(GRB | BAOUT | YIN, 5'd0, 4'd3);
            push_t(COUT | ZIN, 5'd3, 4'd4);
            push_t(ZLO | MARIN, 5'd0, 4'd5);
            if (opc == 5'd0) begin
                if (abort6) begin
                    push(MDRRD | MDRIN, 5'd0, 4'd6, 1'b0, 1'b0, 1'b1, 1'b0);
                    return;
                end
                mem_t(MDRRD | MDRIN, 4'd6, st2, 1'b0);
                push_t(MDROUT | GRA | RIN, 5'd0, 4'd7);
            end else begin
                push_t(GRA | ROUT | MDRIN, 5'd0, 4'd6);
                mem_t(WSIG, 4'd7, st2, 1'b0);
            end
        end else if (opc == 5'd18) begin
            push_t(GRA | ROUT | CONIN, 5'd0, 4'd3);
            push_t(PCOUT | YIN, 5'd0, 4'd4);
            push_t(COUT | ZIN, 5'd3, 4'd5);
            push_t(con ? (ZLO | PCIN) : 21'd0, 5'd0, 4'd6);
        end
    endtask

    task automatic run_q();
        ent_t e;
        while (q.size() > 0) begin
            e = q.pop_front();
            bus.ir_opcode = e.opc;
            bus.con_ff    = e.con;
            bus.mem_ready = e.rdy;
            bus.pause     = e.pau;
            clr           = e.clr;
            #1;
            checks++;
            assert (obs === e.w) else begin
                errors++;
                $error("FAIL trace cycle=%0d instr=%0d obs=%h exp=%h", cyc, e.id, obs, e.w);
            end
            cyc++;
            @(negedge clk);
        end
    endtask

    initial begin
        int r, s1, s2;
        clr = 1'b1;
        bus.ir_opcode = 5'd3;
        bus.con_ff    = 1'b0;
        bus.mem_ready = 1'b1;
        bus.pause     = 1'b0;
        @(negedge clk);

        push_reset(1'b1);
        push_reset(1'b0);
        add_instr(5'd3,  1'b0, 0, 0, 1'b0);
        add_instr(5'd12, 1'b0, 3, 0, 1'b0);
        add_instr(5'd1,  1'b0, 0, 0, 1'b0);
        add_instr(5'd18, 1'b0, 0, 0, 1'b0);
        add_instr(5'd18, 1'b1, 0, 0, 1'b0);
        add_instr(5'd0,  1'b0, 0, 2, 1'b0);
        add_instr(5'd2,  1'b0, 0, WAIT_LIMIT, 1'b0);
        add_instr(5'd31, 1'b0, 0, 0, 1'b0);
        add_instr(5'd26, 1'b0, 0, 0, 1'b0);
        run_q();

        for (int i = 0; i < 30; i++) begin
            r  = $urandom_range(0, 19);
            s1 = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
            s2 = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 6) : 0;
            if (r < 17) add_instr(def_ops[r], 1'($urandom), s1, s2, 1'b0);
            else        add_instr(bad_ops[$urandom_range(0, 13)], 1'($urandom), s1, s2, 1'b0);
        end
        run_q();

        add_instr(5'd0, 1'b0, 0, 0, 1'b0);
        for (int i = q.size() - 4; i < q.size(); i++) q[i].pau = 1'b1;
        m_pau = 1'b1;
        repeat (3) push(21'd0, 5'd0, 4'd0, 1'($urandom), 1'b0, 1'b1, 1'b0);
        m_pau = 1'b0;
        push(21'd0, 5'd0, 4'd0, 1'($urandom), 1'b0, 1'b1, 1'b0);
        add_instr(5'd4, 1'b0, 0, 0, 1'b0);
        add_instr(5'd0, 1'b0, 0, 0, 1'b1);
        do_clr();
        add_instr(5'd13, 1'b0, 1, 0, 1'b0);
        add_instr(5'd27, 1'b0, 0, 0, 1'b0);
        do_clr();
        add_instr(5'd26, 1'b0, 0, 0, 1'b0);
        run_q();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
